// File: rtl/fetch_queue_if.sv
// Shared fetch types plus the I-cache response and decode-side bundles
// used by fetch_queue.
package fq_pkg;
    typedef struct packed {
        logic       ex;
        logic [4:0] code;
    } exception_t;
endpackage

interface icache_resp_if #(
    parameter int FETCH_WIDTH = 2
);
    import fq_pkg::*;
    logic                     icache_data_ok;
    logic [32*FETCH_WIDTH-1:0] icache_rdata;
    logic [31:0]              resp_pc;
    logic [FETCH_WIDTH-1:0]   resp_mask;
    exception_t               resp_ex;

    modport master (
        output icache_data_ok, icache_rdata,
        output resp_pc, resp_mask, resp_ex
    );
    modport slave (
        input icache_data_ok, icache_rdata,
        input resp_pc, resp_mask, resp_ex
    );
endinterface

interface fq_ds_if;
    import fq_pkg::*;
    logic        ds_valid;
    logic        ds_ready;
    logic [31:0] ds_inst;
    logic [31:0] ds_pc;
    exception_t  ds_ex;
    logic        ds_br_op;

    modport master (
        output ds_valid, ds_inst, ds_pc, ds_ex, ds_br_op,
        input  ds_ready
    );
    modport slave (
        input  ds_valid, ds_inst, ds_pc, ds_ex, ds_br_op,
        output ds_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction queue between I-cache responses and decode, one issue per cycle.
// Optional branch predecode under FETCH_QUEUE_PREDECODE_EN.
module fetch_queue
    import fq_pkg::*;
#(
    parameter int FETCH_WIDTH  = 2,
    parameter int DEPTH        = 8,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           req_fire,
    output logic           fq_allowin,
    icache_resp_if.slave   ic,
    input  logic           flush,
    input  logic           bpu_flush,
    input  logic           bpu_keep_head,
    fq_ds_if.master        ds
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    localparam int LW = $clog2(FETCH_WIDTH + 1);

    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic [IW-1:0] inflight, inflight_nxt;
    logic [IW-1:0] cancel_cnt, cancel_nxt;
    logic          keep_one, keep_nxt;

    logic [31:0]   q_inst [DEPTH];
    logic [31:0]   q_pc   [DEPTH];
    exception_t    q_ex   [DEPTH];

    logic          take, deq;
    logic          kill, keep_hold, keep_empty, redirect;
    logic [LW-1:0] n_enq;
    logic [31:0]   w_inst [FETCH_WIDTH];
    logic [31:0]   w_pc   [FETCH_WIDTH];

    assign redirect   = flush || bpu_flush;
    assign kill       = flush || (bpu_flush && !bpu_keep_head);
    assign keep_hold  = !kill && bpu_flush && (count != '0);
    assign keep_empty = !kill && bpu_flush && (count == '0);
    assign deq        = ds.ds_valid && ds.ds_ready;

    // keep_one lets exactly one response through ahead of the cancel counter
    always_comb begin
        take  = ic.icache_data_ok && !redirect &&
                (keep_one || cancel_cnt == '0);
        n_enq = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            w_inst[i] = ic.icache_rdata[32*i +: 32];
            w_pc[i]   = ic.resp_pc + 32'(4 * i);
        end
        if (take) begin
            if (ic.resp_ex.ex) begin
                n_enq     = LW'(1);
                w_inst[0] = '0;
            end else if (keep_one) begin
                n_enq = LW'(ic.resp_mask[0]);
            end else begin
                for (int i = 0; i < FETCH_WIDTH; i++)
                    if (ic.resp_mask[i]) n_enq = LW'(i + 1);
            end
        end
    end

    always_comb begin
        inflight_nxt = inflight + IW'(req_fire) - IW'(ic.icache_data_ok);
        cancel_nxt   = cancel_cnt;
        keep_nxt     = keep_one && !take;
        if (kill || keep_hold) begin
            cancel_nxt = inflight - IW'(ic.icache_data_ok);
            keep_nxt   = 1'b0;
        end else if (keep_empty) begin
            cancel_nxt = (inflight_nxt == '0) ? '0 : inflight_nxt - IW'(1);
            keep_nxt   = 1'b1;
        end else if (ic.icache_data_ok && !keep_one && cancel_cnt != '0) begin
            cancel_nxt = cancel_cnt - IW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            inflight   <= '0;
            cancel_cnt <= '0;
            keep_one   <= 1'b0;
        end else begin
            inflight   <= inflight_nxt;
            cancel_cnt <= cancel_nxt;
            keep_one   <= keep_nxt;
            if (kill) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else if (keep_hold) begin
                tail  <= head + PW'(1);
                count <= CW'(1);
            end else begin
                tail  <= tail + PW'(n_enq);
                head  <= head + PW'(deq);
                count <= count + CW'(n_enq) - CW'(deq);
            end
        end
    end

`ifdef FETCH_QUEUE_PREDECODE_EN
    logic q_br [DEPTH];

    function automatic logic is_br(input logic [31:0] i);
        logic [5:0] op;
        op    = i[31:26];
        is_br = 1'b0;
        unique case (1'b1)
            op inside {[6'h02:6'h07]}: is_br = 1'b1;
            op == 6'h01:               is_br = (i[19:17] == 3'b000);
            op == 6'h00:               is_br = (i[5:1] == 5'b00100);
            default:                   is_br = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk)
        for (int i = 0; i < FETCH_WIDTH; i++)
            if (LW'(i) < n_enq && !ic.resp_ex.ex)
                q_br[tail + PW'(i)] <= is_br(w_inst[i]);
            else if (LW'(i) < n_enq)
                q_br[tail + PW'(i)] <= 1'b0;

    assign ds.ds_br_op = ds.ds_valid && q_br[head];
`else
    assign ds.ds_br_op = 1'b0;
`endif

    always_ff @(posedge clk)
        for (int i = 0; i < FETCH_WIDTH; i++)
            if (LW'(i) < n_enq) begin
                q_inst[tail + PW'(i)] <= w_inst[i];
                q_pc[tail + PW'(i)]   <= w_pc[i];
                q_ex[tail + PW'(i)]   <= ic.resp_ex;
            end

    assign ds.ds_valid = (count != '0) && !redirect;
    assign ds.ds_inst  = (count != '0) ? q_inst[head] : '0;
    assign ds.ds_pc    = (count != '0) ? q_pc[head]   : '0;
    assign ds.ds_ex    = (count != '0) ? q_ex[head]   : '0;

    assign fq_allowin =
        (int'(count) + FETCH_WIDTH * int'(inflight) + FETCH_WIDTH <= DEPTH) &&
        (int'(inflight) < MAX_INFLIGHT);
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: issued entries are popped from an
// expected queue; flush / delay-slot / exception / predecode cases.
module tb_fetch_queue;
    import fq_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [5:0]  ex;
    } ent_t;

    logic clk = 1'b0;
    logic resetn;
    logic req_fire, fq_allowin;
    logic flush, bpu_flush, bpu_keep_head;

    icache_resp_if #(.FETCH_WIDTH(2)) ic ();
    fq_ds_if ds ();

    fetch_queue #(
        .FETCH_WIDTH(2), .DEPTH(8), .MAX_INFLIGHT(2)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_fire     (req_fire),
        .fq_allowin   (fq_allowin),
        .ic           (ic),
        .flush        (flush),
        .bpu_flush    (bpu_flush),
        .bpu_keep_head(bpu_keep_head),
        .ds           (ds)
    );

    always #5 clk = ~clk;

    ent_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic exp_br;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [31:0] pc);
        return {16'h2400, pc[15:0]};
    endfunction

    always @(negedge clk) begin
        if (resetn && ds.ds_valid && ds.ds_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_issue", ds.ds_valid, 1'b0);
            end else begin
                ent_t e;
                e = sb.pop_front();
                chk("ds_pc", ds.ds_pc, e.pc);
                chk("ds_inst", ds.ds_inst, e.inst);
                chk("ds_ex", ds.ds_ex, e.ex);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req();
        req_fire = 1'b1;
        tick();
        req_fire = 1'b0;
    endtask

    // keep = number of lanes expected to reach decode
    task automatic resp(input logic [31:0] pc, input logic [1:0] mask,
                        input logic [5:0] ex, input int keep,
                        input logic [31:0] l0);
        logic [31:0] i0;
        ent_t        e;
        i0 = (l0 == 32'h0) ? mk(pc) : l0;
        ic.icache_rdata   = {mk(pc + 32'd4), i0};
        ic.resp_pc        = pc;
        ic.resp_mask      = mask;
        ic.resp_ex        = exception_t'(ex);
        ic.icache_data_ok = 1'b1;
        if (keep > 0 && ex[5]) begin
            e.pc = pc; e.inst = 32'h0; e.ex = ex;
            sb.push_back(e);
        end else begin
            for (int i = 0; i < keep; i++) begin
                e.pc   = pc + 32'(4 * i);
                e.inst = (i == 0) ? i0 : mk(pc + 32'd4);
                e.ex   = ex;
                sb.push_back(e);
            end
        end
        tick();
        ic.icache_data_ok = 1'b0;
        ic.resp_ex        = '0;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
        tick();
        chk(tag, 64'(sb.size()), 0);
        chk({tag, "_count"}, dut.count, 0);
    endtask

    initial begin
`ifdef FETCH_QUEUE_PREDECODE_EN
        exp_br = 1'b1;
`else
        exp_br = 1'b0;
`endif
        resetn = 1'b0;
        req_fire = 1'b0; flush = 1'b0;
        bpu_flush = 1'b0; bpu_keep_head = 1'b0;
        ic.icache_data_ok = 1'b0; ic.icache_rdata = '0;
        ic.resp_pc = '0; ic.resp_mask = '0; ic.resp_ex = '0;
        ds.ds_ready = 1'b1;
        #12;
        chk("rst_allowin", fq_allowin, 1'b1);
        chk("rst_valid", ds.ds_valid, 1'b0);
        chk("rst_pc", ds.ds_pc, 0);
        chk("rst_inst", ds.ds_inst, 0);
        chk("rst_count", dut.count, 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        tick();

        // basic two-lane response, latency 1
        req();
        resp(32'hBFC00000, 2'b11, 6'h0, 2, 32'h0);
        chk("t1_valid", ds.ds_valid, 1'b1);
        chk("t1_pc0", ds.ds_pc, 32'hBFC00000);
        tick();
        chk("t1_pc1", ds.ds_pc, 32'hBFC00004);
        tick();
        chk("t1_count", dut.count, 0);
        chk("t1_allowin", fq_allowin, 1'b1);

        // fill to full, then drain watching allowin
        ds.ds_ready = 1'b0;
        for (int r = 0; r < 4; r++) begin
            chk("t2_allowin_pre", fq_allowin, 1'b1);
            req();
            resp(32'h1000 + 32'(8 * r), 2'b11, 6'h0, 2, 32'h0);
        end
        chk("t2_count_full", dut.count, 8);
        chk("t2_allowin_full", fq_allowin, 1'b0);
        ds.ds_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t2_count", dut.count, 64'(sb.size()));
            chk("t2_allowin", fq_allowin, sb.size() <= 6);
        end

        // flush drops both in-flight responses
        req();
        req();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t3_cancel2", dut.cancel_cnt, 2);
        resp(32'hDEAD0000, 2'b11, 6'h0, 0, 32'h0);
        chk("t3_cancel1", dut.cancel_cnt, 1);
        resp(32'hDEAD0008, 2'b11, 6'h0, 0, 32'h0);
        chk("t3_cancel0", dut.cancel_cnt, 0);
        chk("t3_count", dut.count, 0);

        // request fired in the flush cycle survives
        req();
        flush = 1'b1;
        req_fire = 1'b1;
        tick();
        flush = 1'b0;
        req_fire = 1'b0;
        chk("t3b_cancel", dut.cancel_cnt, 1);
        resp(32'hDEAD0010, 2'b11, 6'h0, 0, 32'h0);
        resp(32'h2000, 2'b11, 6'h0, 2, 32'h0);
        chk("t3b_pc", ds.ds_pc, 32'h2000);
        drain("t3b_drain");

        // delay slot kept at head
        ds.ds_ready = 1'b0;
        req();
        resp(32'h100, 2'b11, 6'h0, 1, 32'h0);
        req();
        resp(32'h108, 2'b11, 6'h0, 0, 32'h0);
        chk("t4_count4", dut.count, 4);
        bpu_flush = 1'b1;
        bpu_keep_head = 1'b1;
        #1;
        chk("t4_valid_redirect", ds.ds_valid, 1'b0);
        tick();
        bpu_flush = 1'b0;
        bpu_keep_head = 1'b0;
        chk("t4_count1", dut.count, 1);
        chk("t4_pc", ds.ds_pc, 32'h100);
        ds.ds_ready = 1'b1;
        tick();
        chk("t4_count0", dut.count, 0);

        // delay slot still in flight
        req();
        req();
        bpu_flush = 1'b1;
        bpu_keep_head = 1'b1;
        tick();
        bpu_flush = 1'b0;
        bpu_keep_head = 1'b0;
        chk("t5_cancel", dut.cancel_cnt, 1);
        chk("t5_keep_one", dut.keep_one, 1'b1);
        resp(32'h300, 2'b11, 6'h0, 1, 32'h0);
        chk("t5_keep_clr", dut.keep_one, 1'b0);
        chk("t5_pc", ds.ds_pc, 32'h300);
        resp(32'h308, 2'b11, 6'h0, 0, 32'h0);
        chk("t5_cancel0", dut.cancel_cnt, 0);
        drain("t5_drain");

        // fetch exception -> single zero entry
        ds.ds_ready = 1'b0;
        req();
        resp(32'h400, 2'b11, 6'b100101, 1, 32'h0);
        chk("t6_count", dut.count, 1);
        chk("t6_inst", ds.ds_inst, 0);
        chk("t6_ex", ds.ds_ex, 6'b100101);
        ds.ds_ready = 1'b1;
        tick();

        // jr $ra predecode
        ds.ds_ready = 1'b0;
        req();
        resp(32'h500, 2'b11, 6'h0, 2, 32'h03E00008);
        chk("t7_br_jr", ds.ds_br_op, exp_br);
        ds.ds_ready = 1'b1;
        tick();
        chk("t7_br_addiu", ds.ds_br_op, 1'b0);
        drain("t7_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
